// File: rtl/frogger_round_seq.sv
// rtl/frogger_round_seq.sv - Frogger round sequencer: game phase, lives, score and level
module frogger_round_seq #(
    parameter int c_LIVES           = 3,
    parameter int c_GOAL_ROW        = 0,
    parameter int c_DEATH_FRAMES    = 60,
    parameter int c_WIN_FRAMES      = 30,
    parameter int c_FLASH_FRAMES    = 8,
    parameter int c_GOALS_PER_LEVEL = 5,
    parameter int c_MAX_LEVEL       = 7,
    parameter int c_MAX_SCORE       = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic [2:0] o_State,
    output logic       o_Play_En,
    output logic       o_Frog_Reset,
    output logic       o_Flash,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [2:0] o_Level
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PLAY  = 3'd2,
        S_DEATH = 3'd3,
        S_GOAL  = 3'd4,
        S_OVER  = 3'd5
    } t_state;

    localparam logic [1:0] LP_LIVES      = 2'(c_LIVES);
    localparam logic [5:0] LP_GOAL_ROW   = 6'(c_GOAL_ROW);
    localparam logic [6:0] LP_DEATH      = 7'(c_DEATH_FRAMES);
    localparam logic [6:0] LP_WIN        = 7'(c_WIN_FRAMES);
    localparam logic [6:0] LP_FLASH      = 7'(c_FLASH_FRAMES);
    localparam logic [3:0] LP_GOALS      = 4'(c_GOALS_PER_LEVEL);
    localparam logic [2:0] LP_MAX_LEVEL  = 3'(c_MAX_LEVEL);
    localparam logic [6:0] LP_MAX_SCORE  = 7'(c_MAX_SCORE);

    t_state     r_state, w_state_nx;
    logic       r_vsync_q, r_vsync_qq, r_start_q, r_start_qq;
    logic [6:0] r_frame, w_frame_nx;
    logic [3:0] r_goal_cnt, w_goal_cnt_nx, w_goal_inc;
    logic [1:0] r_lives, w_lives_nx;
    logic [6:0] r_score, w_score_nx;
    logic [2:0] r_level, w_level_nx;
    logic       r_play_en, r_frog_reset, r_flash;
    logic       w_vs_tick, w_start_tick;
    logic [6:0] w_flash_div;

    assign w_vs_tick    = r_vsync_q & ~r_vsync_qq;
    assign w_start_tick = r_start_q & ~r_start_qq;
    assign w_goal_inc   = r_goal_cnt + 4'd1;
    assign w_flash_div  = w_frame_nx / LP_FLASH;

    always_comb begin
        w_state_nx    = r_state;
        w_frame_nx    = r_frame;
        w_goal_cnt_nx = r_goal_cnt;
        w_lives_nx    = r_lives;
        w_score_nx    = r_score;
        w_level_nx    = r_level;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_start_tick) begin
                    w_state_nx    = S_START;
                    w_lives_nx    = LP_LIVES;
                    w_score_nx    = 7'd0;
                    w_level_nx    = 3'd0;
                    w_goal_cnt_nx = 4'd0;
                end
            end
            S_START: w_state_nx = S_PLAY;
            S_PLAY: begin
                // A collision on the goal row kills the frog without scoring.
                if (i_Collided) begin
                    w_state_nx = S_DEATH;
                    w_frame_nx = 7'd0;
                    if (r_lives != 2'd0) w_lives_nx = r_lives - 2'd1;
                end else if (i_Frogger_Y == LP_GOAL_ROW) begin
                    w_state_nx = S_GOAL;
                    w_frame_nx = 7'd0;
                    if (r_score != LP_MAX_SCORE) w_score_nx = r_score + 7'd1;
                    if (w_goal_inc >= LP_GOALS) begin
                        w_goal_cnt_nx = 4'd0;
                        if (r_level != LP_MAX_LEVEL) w_level_nx = r_level + 3'd1;
                    end else begin
                        w_goal_cnt_nx = w_goal_inc;
                    end
                end
            end
            S_DEATH: begin
                if (r_frame == LP_DEATH) w_state_nx = (r_lives == 2'd0) ? S_OVER : S_START;
                else if (w_vs_tick)      w_frame_nx = r_frame + 7'd1;
            end
            S_GOAL: begin
                if (r_frame == LP_WIN) w_state_nx = S_START;
                else if (w_vs_tick)    w_frame_nx = r_frame + 7'd1;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with o_State.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state      <= S_IDLE;
            r_vsync_q    <= 1'b0;
            r_vsync_qq   <= 1'b0;
            r_start_q    <= 1'b0;
            r_start_qq   <= 1'b0;
            r_frame      <= 7'd0;
            r_goal_cnt   <= 4'd0;
            r_lives      <= 2'd0;
            r_score      <= 7'd0;
            r_level      <= 3'd0;
            r_play_en    <= 1'b0;
            r_frog_reset <= 1'b0;
            r_flash      <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_vsync_q    <= i_VSync;
            r_vsync_qq   <= r_vsync_q;
            r_start_q    <= i_Game_Start;
            r_start_qq   <= r_start_q;
            r_frame      <= w_frame_nx;
            r_goal_cnt   <= w_goal_cnt_nx;
            r_lives      <= w_lives_nx;
            r_score      <= w_score_nx;
            r_level      <= w_level_nx;
            r_play_en    <= (w_state_nx == S_PLAY);
            r_frog_reset <= (w_state_nx == S_START);
            r_flash      <= (w_state_nx == S_DEATH) & w_flash_div[0];
        end
    end

    assign o_State      = r_state;
    assign o_Play_En    = r_play_en;
    assign o_Frog_Reset = r_frog_reset;
    assign o_Flash      = r_flash;
    assign o_Lives      = r_lives;
    assign o_Score      = r_score;
    assign o_Level      = r_level;

endmodule

// File: tb/tb_frogger_round_seq.sv
// tb/tb_frogger_round_seq.sv - randomized self-checking bench for frogger_round_seq
module tb_frogger_round_seq;

    logic       clk = 1'b0;
    logic       rst_l, vsync, start, collided;
    logic [5:0] frog_y;
    logic [2:0] o_State;
    logic       o_Play_En, o_Frog_Reset, o_Flash;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;
    logic [2:0] o_Level;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase numbers follow the o_State encoding.
    int m_phase, m_frames, m_lives, m_score, m_level, m_goals;
    bit m_vs_seen, m_vs_prev, m_st_seen, m_st_prev;
    int vs_cnt;

    frogger_round_seq dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_VSync      (vsync),
        .i_Game_Start (start),
        .i_Collided   (collided),
        .i_Frogger_Y  (frog_y),
        .o_State      (o_State),
        .o_Play_En    (o_Play_En),
        .o_Frog_Reset (o_Frog_Reset),
        .o_Flash      (o_Flash),
        .o_Lives      (o_Lives),
        .o_Score      (o_Score),
        .o_Level      (o_Level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit vt, st;
        if (!rst_l) begin
            m_phase = 0; m_frames = 0; m_lives = 0; m_score = 0; m_level = 0; m_goals = 0;
            m_vs_seen = 0; m_vs_prev = 0; m_st_seen = 0; m_st_prev = 0;
            return;
        end
        vt = m_vs_seen && !m_vs_prev;
        st = m_st_seen && !m_st_prev;
        m_vs_prev = m_vs_seen; m_vs_seen = vsync;
        m_st_prev = m_st_seen; m_st_seen = start;
        case (m_phase)
            0, 5: if (st) begin
                m_lives = 3; m_score = 0; m_level = 0; m_goals = 0; m_phase = 1;
            end
            1: m_phase = 2;
            2: if (collided) begin
                m_lives = m_lives - 1; m_frames = 0; m_phase = 3;
            end else if (frog_y == 0) begin
                m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
                m_goals = m_goals + 1;
                if (m_goals == 5) begin
                    m_goals = 0;
                    m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
                end
                m_frames = 0; m_phase = 4;
            end
            3: if (m_frames == 60) m_phase = (m_lives == 0) ? 5 : 1;
               else if (vt) m_frames++;
            4: if (m_frames == 30) m_phase = 1;
               else if (vt) m_frames++;
            default: m_phase = 0;
        endcase
    endtask

    task automatic step();
        vs_cnt--;
        if (vs_cnt <= 0) begin
            vsync  = ~vsync;
            vs_cnt = $urandom_range(1, 3);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("state",      o_State,      m_phase);
        check("play_en",    o_Play_En,    m_phase == 2);
        check("frog_reset", o_Frog_Reset, m_phase == 1);
        check("flash",      o_Flash,      (m_phase == 3) && (((m_frames / 8) % 2) == 1));
        check("lives",      o_Lives,      m_lives);
        check("score",      o_Score,      m_score);
        check("level",      o_Level,      m_level);
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (o_State != s && n < budget) begin
            step();
            n++;
        end
        check("wait_state", o_State, s);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        rst_l = 1'b0; vsync = 1'b0; start = 1'b0; collided = 1'b0; frog_y = 6'd20;
        vs_cnt = 2;
        repeat (3) step();
        check("rst_state", o_State, 0);
        check("rst_lives", o_Lives, 0);
        rst_l = 1'b1;

        // Reset and start
        pulse_start();
        check("start_state", o_State, 1);
        check("start_frog_reset", o_Frog_Reset, 1);
        step();
        check("play_state", o_State, 2);
        check("play_lives", o_Lives, 3);
        check("play_en", o_Play_En, 1);

        // Five goals and a level-up
        for (int g = 1; g <= 5; g++) begin
            frog_y = 6'd0;
            wait_state(4, 50);
            check("goal_score", o_Score, g);
            frog_y = 6'($urandom_range(1, 63));
            wait_state(2, 1000);
        end
        check("level_up", o_Level, 1);

        // Collision and goal in the same cycle; start presses during DEATH ignored
        collided = 1'b1; frog_y = 6'd0;
        step();
        collided = 1'b0; frog_y = 6'd9;
        check("tie_state", o_State, 3);
        check("tie_lives", o_Lives, 2);
        check("tie_score", o_Score, 5);
        for (int i = 0; i < 400 && o_State == 3; i++) begin
            start = ($urandom_range(0, 7) == 0);
            step();
        end
        start = 1'b0;
        wait_state(1, 10);

        // Game over then restart
        collided = 1'b1;
        wait_state(5, 3000);
        collided = 1'b0;
        check("over_lives", o_Lives, 0);
        check("over_score", o_Score, 5);
        repeat (20) step();
        pulse_start();
        wait_state(2, 10);
        check("restart_lives", o_Lives, 3);
        check("restart_score", o_Score, 0);
        check("restart_level", o_Level, 0);

        // Saturation: 101 goals
        frog_y = 6'd0;
        for (int g = 0; g < 101; g++) begin
            wait_state(4, 20);
            wait_state(1, 1000);
        end
        frog_y = 6'd30;
        wait_state(2, 10);
        check("sat_score", o_Score, 99);
        check("sat_level", o_Level, 7);

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            collided = ($urandom_range(0, 39) == 0);
            frog_y   = ($urandom_range(0, 29) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            start    = ($urandom_range(0, 49) == 0);
            step();
        end
        collided = 1'b0; start = 1'b0; frog_y = 6'd30;

        // Reset in the middle of DEATH
        rst_l = 1'b0; step(); rst_l = 1'b1;
        pulse_start();
        wait_state(2, 10);
        collided = 1'b1;
        wait_state(3, 10);
        collided = 1'b0;
        for (int i = 0; i < 400 && !(m_phase == 3 && m_frames == 30); i++) step();
        check("mid_frames", (m_phase == 3 && m_frames == 30), 1);
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        check("midrst_state", o_State, 0);
        check("midrst_flash", o_Flash, 0);
        check("midrst_lives", o_Lives, 0);
        repeat (200) step();
        check("idle_hold", o_State, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
